// File: rtl/axi4_lite_pkg.sv
// Shared AXI4-Lite definitions: response codes, master FSM encoding and
// the write-strobe width helper.
package axi4_lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE         = 3'd0,
        ST_WR_ADDR_DATA = 3'd1,
        ST_WR_RESP      = 3'd2,
        ST_RD_ADDR      = 3'd3,
        ST_RD_DATA      = 3'd4,
        ST_RSP_HOLD     = 3'd5
    } state_t;

    // One strobe bit per data byte, never fewer than one bit.
    function automatic int strobe_width(input int data_width);
        return (data_width / 8 < 1) ? 1 : data_width / 8;
    endfunction

endpackage

// File: rtl/basic_axi4_lite_master_if.sv
// Bundle of the command port, response port and the five AXI4-Lite channels
// seen by basic_axi4_lite_master. Signal names are from the master's view.
// Every channel uses valid/ready: a beat transfers on a rising edge where
// VALID and READY are both high; VALID and its payload stay stable until then.
interface basic_axi4_lite_master_if #(
    parameter int p_ADDRESS_WIDTH = 2,
    parameter int p_DATA_WIDTH    = 8
);
    localparam int lp_STROBE_WIDTH = axi4_lite_pkg::strobe_width(p_DATA_WIDTH);

    // Command port
    logic                       i_CMD_VALID;
    logic                       o_CMD_READY;
    logic                       i_CMD_WRITE;
    logic [p_ADDRESS_WIDTH-1:0] i_CMD_ADDR;
    logic [p_DATA_WIDTH-1:0]    i_CMD_WDATA;
    logic [lp_STROBE_WIDTH-1:0] i_CMD_WSTRB;

    // Response port
    logic                       o_RSP_VALID;
    logic                       i_RSP_READY;
    logic                       o_RSP_WRITE;
    logic [p_DATA_WIDTH-1:0]    o_RSP_RDATA;
    logic [1:0]                 o_RSP_RESP;

    // AXI4-Lite channels
    logic [p_ADDRESS_WIDTH-1:0] o_M_AWADDR;
    logic                       o_M_AWPROT;
    logic                       o_M_AWVALID;
    logic                       i_S_AWREADY;
    logic [p_DATA_WIDTH-1:0]    o_M_WDATA;
    logic [lp_STROBE_WIDTH-1:0] o_M_WSTRB;
    logic                       o_M_WVALID;
    logic                       i_S_WREADY;
    logic [1:0]                 i_S_BRESP;
    logic                       i_S_BVALID;
    logic                       o_M_BREADY;
    logic [p_ADDRESS_WIDTH-1:0] o_M_ARADDR;
    logic                       o_M_ARPROT;
    logic                       o_M_ARVALID;
    logic                       i_S_ARREADY;
    logic [p_DATA_WIDTH-1:0]    i_S_RDATA;
    logic [1:0]                 i_S_RRESP;
    logic                       i_S_RVALID;
    logic                       o_M_RREADY;

    modport master (
        input  i_CMD_VALID, i_CMD_WRITE, i_CMD_ADDR, i_CMD_WDATA, i_CMD_WSTRB,
        output o_CMD_READY,
        output o_RSP_VALID, o_RSP_WRITE, o_RSP_RDATA, o_RSP_RESP,
        input  i_RSP_READY,
        output o_M_AWADDR, o_M_AWPROT, o_M_AWVALID,
        input  i_S_AWREADY,
        output o_M_WDATA, o_M_WSTRB, o_M_WVALID,
        input  i_S_WREADY,
        input  i_S_BRESP, i_S_BVALID,
        output o_M_BREADY,
        output o_M_ARADDR, o_M_ARPROT, o_M_ARVALID,
        input  i_S_ARREADY,
        input  i_S_RDATA, i_S_RRESP, i_S_RVALID,
        output o_M_RREADY
    );

    modport slave (
        output i_CMD_VALID, i_CMD_WRITE, i_CMD_ADDR, i_CMD_WDATA, i_CMD_WSTRB,
        input  o_CMD_READY,
        input  o_RSP_VALID, o_RSP_WRITE, o_RSP_RDATA, o_RSP_RESP,
        output i_RSP_READY,
        input  o_M_AWADDR, o_M_AWPROT, o_M_AWVALID,
        output i_S_AWREADY,
        input  o_M_WDATA, o_M_WSTRB, o_M_WVALID,
        output i_S_WREADY,
        output i_S_BRESP, i_S_BVALID,
        input  o_M_BREADY,
        input  o_M_ARADDR, o_M_ARPROT, o_M_ARVALID,
        output i_S_ARREADY,
        output i_S_RDATA, i_S_RRESP, i_S_RVALID,
        input  o_M_RREADY
    );

endinterface

// File: rtl/basic_axi4_lite_master.sv
// Single-outstanding AXI4-Lite master. Takes one read or write command,
// runs the matching bus transaction and holds the result on the response
// port until it is consumed. All outputs come straight from registers.
module basic_axi4_lite_master
    import axi4_lite_pkg::*;
#(
    parameter int p_ADDRESS_WIDTH = 2,
    parameter int p_DATA_WIDTH    = 8
) (
    input  logic                     i_ACLK,
    input  logic                     i_ARESET,
    basic_axi4_lite_master_if.master bus,
    output state_t                   o_DBG_STATE
);
    localparam int lp_STROBE_WIDTH = strobe_width(p_DATA_WIDTH);

    state_t                     state_q;
    logic                       cmd_ready_q;
    logic [p_ADDRESS_WIDTH-1:0] addr_q;
    logic [p_DATA_WIDTH-1:0]    wdata_q;
    logic [lp_STROBE_WIDTH-1:0] wstrb_q;
    logic                       awvalid_q;
    logic                       wvalid_q;
    logic                       aw_done_q;
    logic                       w_done_q;
    logic                       bready_q;
    logic                       arvalid_q;
    logic                       rready_q;
    logic                       rsp_valid_q;
    logic                       rsp_write_q;
    logic [p_DATA_WIDTH-1:0]    rsp_rdata_q;
    logic [1:0]                 rsp_resp_q;

    logic aw_fire;
    logic w_fire;
    logic aw_done_d;
    logic w_done_d;

    // AW and W complete independently; a channel counts as done once it has
    // handshaken in an earlier cycle or is handshaking in this one.
    always_comb begin
        aw_fire   = awvalid_q && bus.i_S_AWREADY;
        w_fire    = wvalid_q && bus.i_S_WREADY;
        aw_done_d = aw_done_q || aw_fire;
        w_done_d  = w_done_q || w_fire;
    end

    // Transaction sequencer: state plus every registered output.
    always_ff @(posedge i_ACLK) begin
        if (i_ARESET) begin
            state_q     <= ST_IDLE;
            cmd_ready_q <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_write_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_resp_q  <= RESP_OKAY;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    cmd_ready_q <= 1'b1;
                    if (bus.i_CMD_VALID && cmd_ready_q) begin
                        cmd_ready_q <= 1'b0;
                        addr_q      <= bus.i_CMD_ADDR;
                        wdata_q     <= bus.i_CMD_WDATA;
                        wstrb_q     <= bus.i_CMD_WSTRB;
                        if (bus.i_CMD_WRITE) begin
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                            aw_done_q <= 1'b0;
                            w_done_q  <= 1'b0;
                            state_q   <= ST_WR_ADDR_DATA;
                        end else begin
                            arvalid_q <= 1'b1;
                            state_q   <= ST_RD_ADDR;
                        end
                    end
                end
                ST_WR_ADDR_DATA: begin
                    if (aw_fire) awvalid_q <= 1'b0;
                    if (w_fire)  wvalid_q  <= 1'b0;
                    aw_done_q <= aw_done_d;
                    w_done_q  <= w_done_d;
                    if (aw_done_d && w_done_d) begin
                        bready_q <= 1'b1;
                        state_q  <= ST_WR_RESP;
                    end
                end
                ST_WR_RESP: begin
                    if (bus.i_S_BVALID && bready_q) begin
                        bready_q    <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_write_q <= 1'b1;
                        rsp_rdata_q <= '0;
                        rsp_resp_q  <= bus.i_S_BRESP;
                        state_q     <= ST_RSP_HOLD;
                    end
                end
                ST_RD_ADDR: begin
                    if (bus.i_S_ARREADY) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= ST_RD_DATA;
                    end
                end
                ST_RD_DATA: begin
                    if (bus.i_S_RVALID && rready_q) begin
                        rready_q    <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_write_q <= 1'b0;
                        rsp_rdata_q <= bus.i_S_RDATA;
                        rsp_resp_q  <= bus.i_S_RRESP;
                        state_q     <= ST_RSP_HOLD;
                    end
                end
                ST_RSP_HOLD: begin
                    if (bus.i_RSP_READY) begin
                        rsp_valid_q <= 1'b0;
                        cmd_ready_q <= 1'b1;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.o_CMD_READY = cmd_ready_q;
    assign bus.o_RSP_VALID = rsp_valid_q;
    assign bus.o_RSP_WRITE = rsp_write_q;
    assign bus.o_RSP_RDATA = rsp_rdata_q;
    assign bus.o_RSP_RESP  = rsp_resp_q;
    assign bus.o_M_AWADDR  = addr_q;
    assign bus.o_M_AWPROT  = 1'b0;
    assign bus.o_M_AWVALID = awvalid_q;
    assign bus.o_M_WDATA   = wdata_q;
    assign bus.o_M_WSTRB   = wstrb_q;
    assign bus.o_M_WVALID  = wvalid_q;
    assign bus.o_M_BREADY  = bready_q;
    assign bus.o_M_ARADDR  = addr_q;
    assign bus.o_M_ARPROT  = 1'b0;
    assign bus.o_M_ARVALID = arvalid_q;
    assign bus.o_M_RREADY  = rready_q;
    assign o_DBG_STATE     = state_q;

endmodule

// File: tb/tb_basic_axi4_lite_master.sv
// Directed bench for basic_axi4_lite_master with a small behavioural
// AXI4-Lite slave (4-byte memory, per-channel READY delays, error injection).
module tb_basic_axi4_lite_master;
    import axi4_lite_pkg::*;

    localparam int AW = 2;
    localparam int DW = 8;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    state_t dbg_state;

    basic_axi4_lite_master_if #(.p_ADDRESS_WIDTH(AW), .p_DATA_WIDTH(DW)) bus_if ();

    basic_axi4_lite_master #(.p_ADDRESS_WIDTH(AW), .p_DATA_WIDTH(DW)) dut (
        .i_ACLK      (clk),
        .i_ARESET    (rst),
        .bus         (bus_if),
        .o_DBG_STATE (dbg_state)
    );

    // ---------------- scoreboard ----------------
    int tests_run    = 0;
    int tests_failed = 0;
    logic [10:0] exp_q[$];   // {write, rdata[7:0], resp[1:0]}
    logic [10:0] mon_e;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Response monitor: samples just before the rising edge.
    always @(negedge clk) begin
        #4;
        if (!rst && bus_if.o_RSP_VALID && bus_if.i_RSP_READY) begin
            if (exp_q.size() == 0) begin
                check("rsp_unexpected", 32'd1, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("rsp_write", bus_if.o_RSP_WRITE, mon_e[10]);
                check("rsp_rdata", bus_if.o_RSP_RDATA, mon_e[9:2]);
                check("rsp_resp",  bus_if.o_RSP_RESP,  mon_e[1:0]);
            end
        end
    end

    // ---------------- slave model ----------------
    int   aw_delay, w_delay, ar_delay;
    logic [1:0] cfg_bresp;
    bit   cfg_rerr;

    logic [7:0] mem [4];
    bit   mem_init = 1'b0;
    bit   aw_got, w_got, ar_got;
    int   aw_cnt, w_cnt, ar_cnt;
    int   aw_hs, w_hs, b_hs, r_hs;
    logic [1:0] aw_addr_l, ar_addr_l;
    logic [7:0] w_data_l;
    logic w_strb_l;
    bit   p_awvalid, p_wvalid, p_bready, p_arvalid, p_rready;

    // Slave acts on falling edges; p_* hold master outputs as they were at
    // the rising edge just passed, so READY && p_VALID means a handshake.
    always @(negedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < 4; i++) mem[i] = 8'h10 + 8'(i);
            mem_init = 1'b1;
        end
        if (rst) begin
            bus_if.i_S_AWREADY = 1'b0;
            bus_if.i_S_WREADY  = 1'b0;
            bus_if.i_S_BVALID  = 1'b0;
            bus_if.i_S_BRESP   = 2'b00;
            bus_if.i_S_ARREADY = 1'b0;
            bus_if.i_S_RVALID  = 1'b0;
            bus_if.i_S_RDATA   = 8'h00;
            bus_if.i_S_RRESP   = 2'b00;
            aw_got = 0; w_got = 0; ar_got = 0;
            aw_cnt = 0; w_cnt = 0; ar_cnt = 0;
            p_awvalid = 0; p_wvalid = 0; p_bready = 0; p_arvalid = 0; p_rready = 0;
        end else begin
            if (bus_if.i_S_AWREADY && p_awvalid) begin
                bus_if.i_S_AWREADY = 1'b0;
                aw_got = 1; aw_cnt = 0; aw_hs++;
                aw_addr_l = bus_if.o_M_AWADDR;
            end else if (!aw_got) begin
                bus_if.i_S_AWREADY = (aw_delay == 0) || (bus_if.o_M_AWVALID && aw_cnt >= aw_delay);
                if (bus_if.o_M_AWVALID && aw_cnt < aw_delay) aw_cnt++;
            end
            if (bus_if.i_S_WREADY && p_wvalid) begin
                bus_if.i_S_WREADY = 1'b0;
                w_got = 1; w_cnt = 0; w_hs++;
                w_data_l = bus_if.o_M_WDATA;
                w_strb_l = bus_if.o_M_WSTRB[0];
            end else if (!w_got) begin
                bus_if.i_S_WREADY = (w_delay == 0) || (bus_if.o_M_WVALID && w_cnt >= w_delay);
                if (bus_if.o_M_WVALID && w_cnt < w_delay) w_cnt++;
            end
            if (bus_if.i_S_BVALID && p_bready) begin
                bus_if.i_S_BVALID = 1'b0;
                aw_got = 0; w_got = 0; b_hs++;
            end else if (aw_got && w_got && !bus_if.i_S_BVALID) begin
                if (w_strb_l) mem[aw_addr_l] = w_data_l;
                bus_if.i_S_BVALID = 1'b1;
                bus_if.i_S_BRESP  = cfg_bresp;
            end
            if (bus_if.i_S_ARREADY && p_arvalid) begin
                bus_if.i_S_ARREADY = 1'b0;
                ar_got = 1; ar_cnt = 0;
                ar_addr_l = bus_if.o_M_ARADDR;
            end else if (!ar_got) begin
                bus_if.i_S_ARREADY = (ar_delay == 0) || (bus_if.o_M_ARVALID && ar_cnt >= ar_delay);
                if (bus_if.o_M_ARVALID && ar_cnt < ar_delay) ar_cnt++;
            end
            if (bus_if.i_S_RVALID && p_rready) begin
                bus_if.i_S_RVALID = 1'b0;
                ar_got = 0; r_hs++;
            end else if (ar_got && !bus_if.i_S_RVALID) begin
                bus_if.i_S_RVALID = 1'b1;
                bus_if.i_S_RDATA  = cfg_rerr ? 8'hFF : mem[ar_addr_l];
                bus_if.i_S_RRESP  = cfg_rerr ? RESP_SLVERR : RESP_OKAY;
            end
            p_awvalid = bus_if.o_M_AWVALID;
            p_wvalid  = bus_if.o_M_WVALID;
            p_bready  = bus_if.o_M_BREADY;
            p_arvalid = bus_if.o_M_ARVALID;
            p_rready  = bus_if.o_M_RREADY;
        end
    end

    // ---------------- driver tasks ----------------
    // Offers a command from a falling edge; returns 1 time unit after the
    // rising edge on which it was accepted.
    task automatic send_cmd(input bit wr, input logic [1:0] addr, input logic [7:0] data,
                            input logic strb);
        bit acc;
        int n;
        @(negedge clk);
        bus_if.i_CMD_VALID = 1'b1;
        bus_if.i_CMD_WRITE = wr;
        bus_if.i_CMD_ADDR  = addr;
        bus_if.i_CMD_WDATA = data;
        bus_if.i_CMD_WSTRB = strb;
        acc = 0;
        n   = 0;
        while (!acc && n < 50) begin
            #4;
            acc = bus_if.o_CMD_READY;
            @(posedge clk);
            n++;
            if (!acc) @(negedge clk);
        end
        #1;
        bus_if.i_CMD_VALID = 1'b0;
        check("cmd_accept", 32'(acc), 32'd1);
    endtask

    // Waits for every expected response to be consumed; returns just after
    // the edge of the last response handshake.
    task automatic wait_drain(input string tag);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        #1;
        check({tag, "_drain"}, exp_q.size(), 32'd0);
    endtask

    task automatic check_all_idle(input string tag);
        check({tag, "_awvalid"},   bus_if.o_M_AWVALID, 32'd0);
        check({tag, "_wvalid"},    bus_if.o_M_WVALID,  32'd0);
        check({tag, "_bready"},    bus_if.o_M_BREADY,  32'd0);
        check({tag, "_arvalid"},   bus_if.o_M_ARVALID, 32'd0);
        check({tag, "_rready"},    bus_if.o_M_RREADY,  32'd0);
        check({tag, "_rsp_valid"}, bus_if.o_RSP_VALID, 32'd0);
        check({tag, "_cmd_ready"}, bus_if.o_CMD_READY, 32'd0);
        check({tag, "_state"},     dbg_state,          ST_IDLE);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n;
        int b_before;
        rst = 1'b1;
        aw_delay = 0; w_delay = 0; ar_delay = 0;
        cfg_bresp = RESP_OKAY; cfg_rerr = 0;
        bus_if.i_CMD_VALID = 1'b0;
        bus_if.i_CMD_WRITE = 1'b0;
        bus_if.i_CMD_ADDR  = '0;
        bus_if.i_CMD_WDATA = '0;
        bus_if.i_CMD_WSTRB = '0;
        bus_if.i_RSP_READY = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_all_idle("reset");
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("reset_cmd_ready", bus_if.o_CMD_READY, 32'd1);

        // T1: write, AW and W accepted together
        exp_q.push_back({1'b1, 8'h00, RESP_OKAY});
        send_cmd(1'b1, 2'd2, 8'h5A, 1'b1);
        check("t1_awvalid",   bus_if.o_M_AWVALID, 32'd1);
        check("t1_wvalid",    bus_if.o_M_WVALID,  32'd1);
        check("t1_awaddr",    bus_if.o_M_AWADDR,  32'd2);
        check("t1_wdata",     bus_if.o_M_WDATA,   32'h5A);
        check("t1_wstrb",     bus_if.o_M_WSTRB,   32'd1);
        check("t1_awprot",    bus_if.o_M_AWPROT,  32'd0);
        check("t1_cmd_ready", bus_if.o_CMD_READY, 32'd0);
        @(posedge clk);
        #1;
        check("t1_aw_drop", bus_if.o_M_AWVALID, 32'd0);
        check("t1_w_drop",  bus_if.o_M_WVALID,  32'd0);
        check("t1_bready",  bus_if.o_M_BREADY,  32'd1);
        check("t1_state",   dbg_state,          ST_WR_RESP);
        @(posedge clk);
        #1;
        check("t1_rsp_valid",   bus_if.o_RSP_VALID, 32'd1);
        check("t1_bready_drop", bus_if.o_M_BREADY,  32'd0);
        wait_drain("t1");
        check("t1_idle_ready", bus_if.o_CMD_READY, 32'd1);

        // T2: AW accepted three cycles before W
        aw_delay = 1;
        w_delay  = 4;
        b_before = b_hs;
        exp_q.push_back({1'b1, 8'h00, RESP_OKAY});
        send_cmd(1'b1, 2'd1, 8'h5A, 1'b1);
        for (int i = 1; i <= 5; i++) begin
            @(posedge clk);
            #1;
            check("t2_awvalid", bus_if.o_M_AWVALID, (i < 2) ? 32'd1 : 32'd0);
            check("t2_wvalid",  bus_if.o_M_WVALID,  (i < 5) ? 32'd1 : 32'd0);
            if (bus_if.o_M_WVALID) check("t2_wdata", bus_if.o_M_WDATA, 32'h5A);
        end
        wait_drain("t2");
        check("t2_b_count", b_hs - b_before, 32'd1);
        aw_delay = 0;
        w_delay  = 0;

        // T3: read back, then a read with a slow AR
        exp_q.push_back({1'b0, 8'h5A, RESP_OKAY});
        send_cmd(1'b0, 2'd2, 8'h00, 1'b0);
        check("t3_arvalid", bus_if.o_M_ARVALID, 32'd1);
        check("t3_araddr",  bus_if.o_M_ARADDR,  32'd2);
        wait_drain("t3a");
        ar_delay = 2;
        exp_q.push_back({1'b0, 8'h5A, RESP_OKAY});
        send_cmd(1'b0, 2'd1, 8'h00, 1'b0);
        @(posedge clk);
        #1;
        check("t3_ar_hold", bus_if.o_M_ARVALID, 32'd1);
        wait_drain("t3b");
        ar_delay = 0;

        // Strobe off + SLVERR on B: memory untouched, error passed through
        cfg_bresp = RESP_SLVERR;
        exp_q.push_back({1'b1, 8'h00, RESP_SLVERR});
        send_cmd(1'b1, 2'd3, 8'h96, 1'b0);
        wait_drain("t3c");
        cfg_bresp = RESP_OKAY;
        exp_q.push_back({1'b0, 8'h13, RESP_OKAY});
        send_cmd(1'b0, 2'd3, 8'h00, 1'b0);
        wait_drain("t3d");

        // T4: response backpressure with a second command waiting
        @(negedge clk);
        bus_if.i_RSP_READY = 1'b0;
        exp_q.push_back({1'b0, 8'h10, RESP_OKAY});
        send_cmd(1'b0, 2'd0, 8'h00, 1'b0);
        n = 0;
        while (!bus_if.o_RSP_VALID && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("t4_rsp_seen", bus_if.o_RSP_VALID, 32'd1);
        @(negedge clk);
        exp_q.push_back({1'b1, 8'h00, RESP_OKAY});
        bus_if.i_CMD_VALID = 1'b1;
        bus_if.i_CMD_WRITE = 1'b1;
        bus_if.i_CMD_ADDR  = 2'd0;
        bus_if.i_CMD_WDATA = 8'h77;
        bus_if.i_CMD_WSTRB = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("t4_hold_valid", bus_if.o_RSP_VALID, 32'd1);
            check("t4_hold_rdata", bus_if.o_RSP_RDATA, 32'h10);
            check("t4_hold_write", bus_if.o_RSP_WRITE, 32'd0);
            check("t4_cmd_ready",  bus_if.o_CMD_READY, 32'd0);
            check("t4_state",      dbg_state,          ST_RSP_HOLD);
        end
        @(negedge clk);
        bus_if.i_RSP_READY = 1'b1;
        @(posedge clk);
        #1;
        check("t4_rsp_drop",    bus_if.o_RSP_VALID, 32'd0);
        check("t4_ready_again", bus_if.o_CMD_READY, 32'd1);
        @(posedge clk);
        #1;
        bus_if.i_CMD_VALID = 1'b0;
        check("t4_second_state",   dbg_state,          ST_WR_ADDR_DATA);
        check("t4_second_awvalid", bus_if.o_M_AWVALID, 32'd1);
        check("t4_second_wdata",   bus_if.o_M_WDATA,   32'h77);
        wait_drain("t4a");
        exp_q.push_back({1'b0, 8'h77, RESP_OKAY});
        send_cmd(1'b0, 2'd0, 8'h00, 1'b0);
        wait_drain("t4b");

        // T5: read error passed through
        cfg_rerr = 1;
        exp_q.push_back({1'b0, 8'hFF, RESP_SLVERR});
        send_cmd(1'b0, 2'd0, 8'h00, 1'b0);
        wait_drain("t5");
        cfg_rerr = 0;

        // T6: reset in the middle of a stalled write
        aw_delay = 20;
        w_delay  = 20;
        send_cmd(1'b1, 2'd3, 8'h99, 1'b1);
        check("t6_awvalid", bus_if.o_M_AWVALID, 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_all_idle("t6_rst");
        @(negedge clk);
        rst      = 1'b0;
        aw_delay = 0;
        w_delay  = 0;
        @(posedge clk);
        #1;
        check("t6_cmd_ready", bus_if.o_CMD_READY, 32'd1);
        check("t6_no_rsp",    bus_if.o_RSP_VALID, 32'd0);
        exp_q.push_back({1'b1, 8'h00, RESP_OKAY});
        send_cmd(1'b1, 2'd0, 8'h42, 1'b1);
        wait_drain("t6a");
        exp_q.push_back({1'b0, 8'h42, RESP_OKAY});
        send_cmd(1'b0, 2'd0, 8'h00, 1'b0);
        wait_drain("t6b");

        repeat (3) @(posedge clk);
        #1;
        check("final_queue_empty", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Hard stop if something stalls beyond every per-step budget.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
